// File: rtl/shift_add_scheduler_if.sv
// Operand/result handshake bundle for shift_add_scheduler.
// The slave modport is the scheduler side; the master modport is the producer/consumer side.
interface shift_add_scheduler_if #(
    parameter int WIDTH = 38
) ();
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] out_data;
    logic                    out_ovf;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/shift_add_scheduler.sv
// Iterative acc += acc >>> shift[step] scheduler driven by a small shift table.
// Define SHIFT_ADD_SAT_EN to saturate overflowing steps and report out_ovf; otherwise steps wrap.
//
//   state | meaning
//   IDLE  | waiting for an operand, config writes accepted
//   RUN   | one shift-add step per cycle from the captured table
//   DONE  | result held on out_data until out_ready
module shift_add_scheduler #(
    parameter int WIDTH     = 38,
    parameter int MAX_STEPS = 8,
    parameter int SHIFT_W   = 6,
    localparam int AW = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1,
    localparam int LW = AW + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [AW-1:0]       cfg_addr,
    input  logic [SHIFT_W-1:0]  cfg_shift,
    input  logic                cfg_len_we,
    input  logic [LW-1:0]       cfg_len,
    shift_add_scheduler_if.slave bus,
    output logic                busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state;
    logic [SHIFT_W-1:0]      tab     [MAX_STEPS];
    logic [SHIFT_W-1:0]      run_tab [MAX_STEPS];
    logic [LW-1:0]           len_q;
    logic [LW-1:0]           run_len;
    logic [LW-1:0]           step;
    logic signed [WIDTH-1:0] acc;
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic                    busy_q;

    logic [SHIFT_W-1:0]      cur_shift;
    logic signed [WIDTH-1:0] shifted;
    logic signed [WIDTH-1:0] next_acc;
    logic [LW-1:0]           len_clamped;

`ifdef SHIFT_ADD_SAT_EN
    localparam logic signed [WIDTH-1:0] ACC_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] ACC_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    logic [WIDTH:0] sum;
    logic           step_ovf;
    logic           ovf_q;
`endif

    always_comb begin
        cur_shift = run_tab[step[AW-1:0]];
        if (int'(cur_shift) >= WIDTH) begin
            shifted = {WIDTH{acc[WIDTH-1]}};
        end else begin
            shifted = acc >>> cur_shift;
        end
`ifdef SHIFT_ADD_SAT_EN
        sum      = {acc[WIDTH-1], acc} + {shifted[WIDTH-1], shifted};
        step_ovf = sum[WIDTH] ^ sum[WIDTH-1];
        if (step_ovf) begin
            next_acc = sum[WIDTH] ? ACC_MIN : ACC_MAX;
        end else begin
            next_acc = sum[WIDTH-1:0];
        end
`else
        // In wrap mode the extra carry bit would be discarded anyway.
        next_acc = acc + shifted;
`endif
    end

    always_comb begin
        len_clamped = cfg_len;
        if (cfg_len > LW'(MAX_STEPS)) begin
            len_clamped = LW'(MAX_STEPS);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            acc         <= '0;
            step        <= '0;
            len_q       <= '0;
            run_len     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SHIFT_ADD_SAT_EN
            ovf_q       <= 1'b0;
`endif
            for (int i = 0; i < MAX_STEPS; i++) begin
                tab[i]     <= '0;
                run_tab[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (cfg_we) begin
                        tab[cfg_addr] <= cfg_shift;
                    end
                    if (cfg_len_we) begin
                        len_q <= len_clamped;
                    end
                    if (bus.in_valid && in_ready_q) begin
                        // Snapshot table and length so a same-cycle write applies to the next operand only.
                        acc        <= bus.in_data;
                        step       <= '0;
                        run_tab    <= tab;
                        run_len    <= len_q;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
`ifdef SHIFT_ADD_SAT_EN
                        ovf_q      <= 1'b0;
`endif
                        state      <= (len_q != '0) ? RUN : DONE;
                    end
                end
                RUN: begin
                    acc  <= next_acc;
                    step <= step + LW'(1);
`ifdef SHIFT_ADD_SAT_EN
                    if (step_ovf) begin
                        ovf_q <= 1'b1;
                    end
`endif
                    if (step + LW'(1) == run_len) begin
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    // A zero-length operand arrives here with out_valid low; raise it one cycle later.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = acc;
`ifdef SHIFT_ADD_SAT_EN
    assign bus.out_ovf   = ovf_q;
`else
    assign bus.out_ovf   = 1'b0;
`endif
    assign busy          = busy_q;

endmodule

// File: tb/tb_shift_add_scheduler.sv
// Randomized bench for shift_add_scheduler against a transaction-level arithmetic model.
// Honours SHIFT_ADD_SAT_EN the same way as the design.
module tb_shift_add_scheduler;
    localparam int WIDTH     = 38;
    localparam int MAX_STEPS = 8;
    localparam int SHIFT_W   = 6;
    localparam longint MAXV  = (64'sd1 <<< (WIDTH-1)) - 64'sd1;
    localparam longint MINV  = -(64'sd1 <<< (WIDTH-1));
    localparam longint MODV  = 64'sd1 <<< WIDTH;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cfg_we = 1'b0;
    logic [2:0]         cfg_addr = '0;
    logic [SHIFT_W-1:0] cfg_shift = '0;
    logic               cfg_len_we = 1'b0;
    logic [3:0]         cfg_len = '0;
    logic               busy;

    int checks = 0;
    int errors = 0;

    shift_add_scheduler_if #(.WIDTH(WIDTH)) bus ();

    shift_add_scheduler #(.WIDTH(WIDTH), .MAX_STEPS(MAX_STEPS), .SHIFT_W(SHIFT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_shift  (cfg_shift),
        .cfg_len_we (cfg_len_we),
        .cfg_len    (cfg_len),
        .bus        (bus),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, req);
        end
    endtask

    // Model state: configuration as the spec describes it, plus one outstanding operand.
    int     m_tab [MAX_STEPS];
    int     m_len;
    bit     pending;
    int     age;
    int     lat;
    int     released;
    longint exp_data;
    bit     exp_ovf;
    bit     was_idle;

    function automatic void model_run(input longint d, input int n, output longint r, output bit o);
        longint a = d;
        longint sh;
        longint s;
        o = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (m_tab[i] >= WIDTH) sh = (a < 0) ? -64'sd1 : 64'sd0;
            else                   sh = a >>> m_tab[i];
            s = a + sh;
            if (s > MAXV || s < MINV) begin
`ifdef SHIFT_ADD_SAT_EN
                o = 1'b1;
                a = (s > MAXV) ? MAXV : MINV;
`else
                a = (s > MAXV) ? s - MODV : s + MODV;
`endif
            end else begin
                a = s;
            end
        end
        r = a;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending  = 1'b0;
            age      = 0;
            lat      = 0;
            m_len    = 0;
            released = 0;
            for (int i = 0; i < MAX_STEPS; i++) m_tab[i] = 0;
        end else begin
            was_idle = !pending;
            if (pending) begin
                if (age >= lat && bus.out_ready) pending = 1'b0;
                else age++;
            end
            if (was_idle) begin
                if (bus.in_valid && bus.in_ready) begin
                    model_run(longint'(bus.in_data), m_len, exp_data, exp_ovf);
                    lat     = (m_len > 0) ? m_len : 1;
                    age     = 0;
                    pending = 1'b1;
                end
                if (cfg_we) m_tab[cfg_addr] = int'(cfg_shift);
                if (cfg_len_we) m_len = (int'(cfg_len) > MAX_STEPS) ? MAX_STEPS : int'(cfg_len);
            end
            if (released < 1000) released++;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("rst_out_valid", longint'(bus.out_valid), 0);
            check("rst_in_ready", longint'(bus.in_ready), 0);
            check("rst_busy", longint'(busy), 0);
            check("rst_out_data", longint'(bus.out_data), 0);
            check("rst_out_ovf", longint'(bus.out_ovf), 0);
        end else begin
            check("out_valid", longint'(bus.out_valid), longint'(pending && age >= lat));
            check("busy", longint'(busy), longint'(pending));
            if (released >= 1) check("in_ready", longint'(bus.in_ready), longint'(!pending));
            if (pending && age >= lat) begin
                check("out_data", longint'(bus.out_data), exp_data);
                check("out_ovf", longint'(bus.out_ovf), longint'(exp_ovf));
            end
        end
    end

    task automatic wr_shift(input int a, input int s);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 3'(a); cfg_shift = 6'(s);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic wr_len(input int l);
        @(negedge clk);
        cfg_len_we = 1'b1; cfg_len = 4'(l);
        @(negedge clk);
        cfg_len_we = 1'b0;
    endtask

    task automatic run_op(input longint d, input int hold, input bit noise,
                          input bit co_we, input int co_addr, input int co_shift,
                          input bit co_lwe, input int co_len,
                          output longint res, output bit ovf, output int lat_seen);
        bit accepted = 1'b0;
        bit got = 1'b0;
        int n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = WIDTH'(d);
        cfg_we = co_we; cfg_addr = 3'(co_addr); cfg_shift = 6'(co_shift);
        cfg_len_we = co_lwe; cfg_len = 4'(co_len);
        for (int i = 0; i < 20 && !accepted; i++) begin
            @(posedge clk);
            if (bus.in_ready) accepted = 1'b1;
        end
        check("accept_seen", longint'(accepted), 1);
        @(negedge clk);
        bus.in_valid = 1'b0; cfg_we = 1'b0; cfg_len_we = 1'b0;
        while (n < 20) begin
            if (bus.out_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            n++;
        end
        check("out_valid_seen", longint'(got), 1);
        res = longint'(bus.out_data); ovf = bus.out_ovf; lat_seen = n;
        for (int h = 0; h < hold; h++) begin
            cfg_we = noise; cfg_addr = 3'($urandom_range(0, 7)); cfg_shift = 6'($urandom_range(0, 63));
            cfg_len_we = noise; cfg_len = 4'($urandom_range(0, 15));
            @(negedge clk);
        end
        cfg_we = 1'b0; cfg_len_we = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    function automatic longint rand_data();
        longint d;
        case ($urandom_range(0, 4))
            0: d = MAXV;
            1: d = MINV;
            2: d = longint'($urandom_range(0, 2000)) - 64'sd1000;
            default: begin
                d = longint'({$urandom, $urandom});
                d = (d <<< (64 - WIDTH)) >>> (64 - WIDTH);
            end
        endcase
        return d;
    endfunction

    function automatic int rand_shift();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 6));
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        longint r;
        bit     o;
        int     l;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        #3 rst = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);

        // Single step, shift 16: 65536 + 1
        wr_shift(0, 16); wr_len(1);
        run_op(65536, 0, 0, 0, 0, 0, 0, 0, r, o, l);
        check("r34_data", r, 65537); check("r34_ovf", longint'(o), 0); check("r34_lat", l, 1);

        // Two steps of shift 1: 4 -> 6 -> 9; zero length passes data through
        wr_shift(0, 1); wr_shift(1, 1); wr_len(2);
        run_op(4, 0, 0, 0, 0, 0, 0, 0, r, o, l);
        check("r35_data", r, 9); check("r35_lat", l, 2);
        wr_len(0);
        run_op(-5, 0, 0, 0, 0, 0, 0, 0, r, o, l);
        check("r35_zero_data", r, -5); check("r35_zero_lat", l, 1);

        // Doubling the most positive value overflows
        wr_shift(0, 0); wr_len(1);
        run_op(MAXV, 0, 0, 0, 0, 0, 0, 0, r, o, l);
`ifdef SHIFT_ADD_SAT_EN
        check("r36_data", r, MAXV); check("r36_ovf", longint'(o), 1);
`else
        check("r36_data", r, -2); check("r36_ovf", longint'(o), 0);
`endif

        // Hold in DONE with config writes that must be ignored
        wr_shift(0, 3); wr_len(1);
        run_op(800, 5, 1, 0, 0, 0, 0, 0, r, o, l);
        check("r37_data", r, 900);
        run_op(80, 0, 0, 0, 0, 0, 0, 0, r, o, l);
        check("r37_cfg_kept", r, 90); check("r37_lat", l, 1);

        // Same-cycle write and accept: operand sees old table/length
        wr_shift(1, 1); wr_shift(2, 1); wr_shift(0, 2); wr_len(1);
        run_op(100, 0, 0, 1, 0, 0, 1, 3, r, o, l);
        check("r28_old_data", r, 125); check("r28_old_lat", l, 1);
        run_op(8, 0, 0, 0, 0, 0, 0, 0, r, o, l);
        check("r28_new_data", r, 36); check("r28_new_lat", l, 3);

        // Shifts at or beyond WIDTH add sign bits; length above MAX_STEPS clamps
        for (int i = 0; i < MAX_STEPS; i++) wr_shift(i, 40);
        wr_len(15);
        run_op(-7, 0, 0, 0, 0, 0, 0, 0, r, o, l);
        check("r26_data", r, -15); check("r26_lat", l, 8);
        wr_shift(0, 63); wr_len(1);
        run_op(12345, 0, 0, 0, 0, 0, 0, 0, r, o, l);
        check("r25_pos", r, 12345);

        // Reset during step 1 of 3
        wr_shift(0, 1); wr_shift(1, 2); wr_shift(2, 3); wr_len(3);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = WIDTH'(1000);
        @(posedge clk);
        check("r38_accept", longint'(bus.in_ready), 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("r38_out_valid", longint'(bus.out_valid), 0);
        check("r38_busy", longint'(busy), 0);
        check("r38_out_data", longint'(bus.out_data), 0);
        check("r38_out_ovf", longint'(bus.out_ovf), 0);
        check("r38_in_ready", longint'(bus.in_ready), 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check("r38_ready_after", longint'(bus.in_ready), 1);
        check("r38_no_stale", longint'(bus.out_valid), 0);
        repeat (5) @(negedge clk);
        run_op(11, 0, 0, 0, 0, 0, 0, 0, r, o, l);
        check("r30_len_reset", r, 11); check("r30_len_lat", l, 1);
        wr_len(1);
        run_op(3, 0, 0, 0, 0, 0, 0, 0, r, o, l);
        check("r30_tab_reset", r, 6);

        // Randomized traffic; the compare process checks every cycle
        for (int it = 0; it < 250; it++) begin
            int  nw = $urandom_range(0, 3);
            bit  co = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < nw; k++) wr_shift($urandom_range(0, 7), rand_shift());
            if ($urandom_range(0, 2) == 0) wr_len($urandom_range(0, 15));
            run_op(rand_data(), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                   co, $urandom_range(0, 7), rand_shift(),
                   co && ($urandom_range(0, 1) == 1), $urandom_range(0, 15), r, o, l);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
